data_mem_responder: RTL

Word-organised data memory that answers the pipelined CPU's load/store requests over a valid/ready request channel and a valid/ready response channel. It is the responder end of the CPU data-memory interface, with a programmable fixed access latency, so the pipeline's stall logic can be exercised against a multi-cycle memory. It keeps one outstanding transaction, applies byte-enabled writes and flags out-of-range addresses.

---
 rtl/data_mem_responder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering CPU load/store requests.
// One outstanding transaction, programmable access latency, range check.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [29:0] wa;
    logic [31:0] wd;
  } req_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  req_t rq, inq, cq;
  logic accept, commit, oor;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0] rd_n;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic unused_lsb;

  assign unused_lsb = ^req_addr[1:0];

  assign inq = '{
    we: req_we,
    be: req_byteen,
    wa: req_addr[31:2],
    wd: req_wdata
  };

  // With single-cycle latency the commit uses the live request
  assign cq  = (state == IDLE) ? inq : rq;
  assign idx = cq.wa[ADDR_WIDTH-1:0];
  assign oor = (cq.wa >> ADDR_WIDTH) != '0;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = (state == IDLE) && req_valid;
  assign commit     = reset && (state != RESP)
                      && (state_n == RESP);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          cnt_n   = CNT_INIT;
          state_n = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_n = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rd_n = '0;
    if (!oor && !cq.we) begin
      rd_n = mem[idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rq         <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        rq <= inq;
      end
      if (commit) begin
        resp_rdata <= rd_n;
        resp_err   <= oor;
      end else if (resp_valid && resp_ready) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end

  // Array is deliberately unreset; only control state clears
  always_ff @(posedge clk) begin
    if (commit && cq.we && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (cq.be[i]) begin
          mem[idx][8*i +: 8] <= cq.wd[8*i +: 8];
        end
      end
    end
  end

endmodule
